avsdpll_lock_ctrl: RTL and testbench

Parametrised digital controller for the analog PLL macro. Sequences the active-low charge-pump and VCO enables and drives the feedback divider code. Measures PLL output frequency against the reference over a programmable window and reports lock, loss of lock and acquisition fault. Runs entirely in the CLK domain; REF and PLL edges arrive as pre-synchronised one-cycle tick strobes.

---
 rtl/avsdpll_lock_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_avsdpll_lock_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avsdpll_lock_ctrl.sv
// rtl/avsdpll_lock_ctrl.sv - PLL macro power sequencer and frequency lock monitor
// Sequences CP/VCO enables, drives the divider code and judges lock from windowed tick counts.
module avsdpll_lock_ctrl #(
  parameter int DIV_W         = 4,
  parameter int WIN_W         = 8,
  parameter int CNT_W         = 16,
  parameter int TOL_W         = 8,
  parameter int CP_SETTLE     = 16,
  parameter int VCO_SETTLE    = 1024,
  parameter int LOCK_HITS     = 4,
  parameter int UNLOCK_MISSES = 2,
  parameter int ACQ_TIMEOUT   = 64
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic [WIN_W-1:0] WIN,
  input  logic [TOL_W-1:0] TOL,
  input  logic             REF_TICK,
  input  logic             PLL_TICK,
  output logic             ENb_CP,
  output logic             ENb_VCO,
  output logic [DIV_W-1:0] B,
  output logic             LOCK,
  output logic             FAULT,
  output logic [CNT_W-1:0] FREQ_CNT,
  output logic             CNT_VALID,
  output logic [2:0]       STATE
);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_CP_ON  = 3'd1;
  localparam logic [2:0] ST_VCO_ON = 3'd2;
  localparam logic [2:0] ST_ACQ    = 3'd3;
  localparam logic [2:0] ST_LOCKED = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam int SETTLE_MAX = (CP_SETTLE > VCO_SETTLE) ? CP_SETTLE : VCO_SETTLE;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);
  localparam int HIT_W      = $clog2(LOCK_HITS + 1);
  localparam int MISS_W     = $clog2(UNLOCK_MISSES + 1);
  localparam int TMO_W      = $clog2(ACQ_TIMEOUT + 1);
  localparam int PROD_W     = WIN_W + DIV_W;
  localparam int CMP_A      = (CNT_W > PROD_W) ? CNT_W : PROD_W;
  // One spare bit so the signed difference of two unsigned operands never wraps.
  localparam int CMP_W      = ((CMP_A > TOL_W) ? CMP_A : TOL_W) + 1;

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [WIN_W-1:0]    win_len;
  logic [WIN_W-1:0]    ref_cnt;
  logic                win_open;
  logic [CNT_W-1:0]    pll_cnt;
  logic [CNT_W-1:0]    pll_sum;
  logic [HIT_W-1:0]    hit_cnt;
  logic [MISS_W-1:0]   miss_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [DIV_W-1:0]    div_eff;
  logic [WIN_W-1:0]    win_eff;
  logic [CMP_W-1:0]    expected;
  logic [CMP_W-1:0]    diff;
  logic [CMP_W-1:0]    abs_diff;
  logic                measuring;
  logic                div_chg;
  logic                win_active;
  logic                win_close;
  logic                win_pass;
  logic                cp_done;
  logic                vco_done;
  logic                lock_now;
  logic                unlock_now;
  logic                fault_now;

  assign div_eff    = (DIV == '0) ? DIV_W'(1) : DIV;
  assign win_eff    = (WIN == '0) ? WIN_W'(1) : WIN;
  assign measuring  = (state == ST_ACQ) || (state == ST_LOCKED);
  assign div_chg    = measuring && (div_eff != B);
  assign win_active = measuring && EN && !div_chg;

  // A PLL tick on the closing REF tick still belongs to the closing window.
  assign pll_sum   = (PLL_TICK && (pll_cnt != {CNT_W{1'b1}})) ? pll_cnt + CNT_W'(1) : pll_cnt;
  assign win_close = win_active && win_open && REF_TICK && (ref_cnt == win_len - WIN_W'(1));

  assign expected = CMP_W'(win_len) * CMP_W'(B);
  assign diff     = CMP_W'(pll_sum) - expected;
  assign abs_diff = diff[CMP_W-1] ? (~diff + CMP_W'(1)) : diff;
  assign win_pass = (abs_diff <= CMP_W'(TOL));

  assign cp_done    = (state == ST_CP_ON) && (settle_cnt == SETTLE_W'(CP_SETTLE - 1));
  assign vco_done   = (state == ST_VCO_ON) && (settle_cnt == SETTLE_W'(VCO_SETTLE - 1));
  assign lock_now   = win_close && win_pass && (state == ST_ACQ) &&
                      (hit_cnt == HIT_W'(LOCK_HITS - 1));
  assign fault_now  = win_close && !win_pass && (state == ST_ACQ) &&
                      (tmo_cnt == TMO_W'(ACQ_TIMEOUT - 1));
  assign unlock_now = win_close && !win_pass && (state == ST_LOCKED) &&
                      (miss_cnt == MISS_W'(UNLOCK_MISSES - 1));

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state <= ST_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!EN) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF:    state_nxt = ST_CP_ON;
        ST_CP_ON:  if (cp_done) state_nxt = ST_VCO_ON;
        ST_VCO_ON: if (vco_done) state_nxt = ST_ACQ;
        ST_ACQ: begin
          if (div_chg)        state_nxt = ST_ACQ;
          else if (lock_now)  state_nxt = ST_LOCKED;
          else if (fault_now) state_nxt = ST_FAULT;
        end
        ST_LOCKED: begin
          if (div_chg || unlock_now) state_nxt = ST_ACQ;
        end
        ST_FAULT:  state_nxt = ST_FAULT;
        default:   state_nxt = ST_OFF;
      endcase
    end
  end

  always_comb begin
    ENb_CP  = 1'b1;
    ENb_VCO = 1'b1;
    LOCK    = 1'b0;
    FAULT   = 1'b0;
    STATE   = state;
    case (state)
      ST_CP_ON:  ENb_CP = 1'b0;
      ST_VCO_ON: begin ENb_CP = 1'b0; ENb_VCO = 1'b0; end
      ST_ACQ:    begin ENb_CP = 1'b0; ENb_VCO = 1'b0; end
      ST_LOCKED: begin ENb_CP = 1'b0; ENb_VCO = 1'b0; LOCK = 1'b1; end
      ST_FAULT:  FAULT = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      B          <= '0;
      win_len    <= '0;
      FREQ_CNT   <= '0;
      CNT_VALID  <= 1'b0;
      settle_cnt <= '0;
      win_open   <= 1'b0;
      ref_cnt    <= '0;
      pll_cnt    <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      CNT_VALID <= 1'b0;

      if ((state_nxt == state) && ((state == ST_CP_ON) || (state == ST_VCO_ON))) begin
        settle_cnt <= settle_cnt + SETTLE_W'(1);
      end else begin
        settle_cnt <= '0;
      end

      if ((state == ST_OFF) && EN) begin
        B       <= div_eff;
        win_len <= win_eff;
      end else if (div_chg && EN) begin
        B <= div_eff;
      end

      // The closing REF tick immediately starts the next window.
      if (!win_active) begin
        win_open <= 1'b0;
        ref_cnt  <= '0;
        pll_cnt  <= '0;
      end else if (!win_open) begin
        win_open <= REF_TICK;
        ref_cnt  <= '0;
        pll_cnt  <= '0;
      end else if (win_close) begin
        FREQ_CNT  <= pll_sum;
        CNT_VALID <= 1'b1;
        ref_cnt   <= '0;
        pll_cnt   <= '0;
      end else begin
        if (REF_TICK) ref_cnt <= ref_cnt + WIN_W'(1);
        pll_cnt <= pll_sum;
      end

      if (!win_active) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
        tmo_cnt  <= '0;
      end else if (win_close) begin
        if (state == ST_ACQ) begin
          if (win_pass) begin
            if (lock_now) begin
              hit_cnt  <= '0;
              miss_cnt <= '0;
            end else begin
              hit_cnt <= hit_cnt + HIT_W'(1);
            end
          end else begin
            hit_cnt <= '0;
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end else begin
          if (win_pass) begin
            miss_cnt <= '0;
          end else if (unlock_now) begin
            miss_cnt <= '0;
            hit_cnt  <= '0;
            tmo_cnt  <= '0;
          end else begin
            miss_cnt <= miss_cnt + MISS_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_avsdpll_lock_ctrl.sv
// tb/tb_avsdpll_lock_ctrl.sv - randomized scoreboard bench for avsdpll_lock_ctrl
module tb_avsdpll_lock_ctrl;

  localparam int DIV_W  = 4;
  localparam int WIN_W  = 8;
  localparam int CNT_W  = 16;
  localparam int TOL_W  = 8;
  localparam int CP_S   = 16;
  localparam int VCO_S  = 32;
  localparam int HITS   = 4;
  localparam int MISSES = 2;
  localparam int TMO    = 4;
  localparam int GAP    = 12;

  logic             clk = 1'b0;
  logic             rstb = 1'b0;
  logic             en = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [WIN_W-1:0] win = '0;
  logic [TOL_W-1:0] tol = '0;
  logic             ref_tick = 1'b0;
  logic             pll_tick = 1'b0;
  logic             enb_cp;
  logic             enb_vco;
  logic [DIV_W-1:0] b;
  logic             lock;
  logic             fault;
  logic [CNT_W-1:0] freq_cnt;
  logic             cnt_valid;
  logic [2:0]       state;

  avsdpll_lock_ctrl #(
    .DIV_W(DIV_W), .WIN_W(WIN_W), .CNT_W(CNT_W), .TOL_W(TOL_W),
    .CP_SETTLE(CP_S), .VCO_SETTLE(VCO_S), .LOCK_HITS(HITS),
    .UNLOCK_MISSES(MISSES), .ACQ_TIMEOUT(TMO)
  ) dut (
    .CLK(clk), .RSTb(rstb), .EN(en), .DIV(div), .WIN(win), .TOL(tol),
    .REF_TICK(ref_tick), .PLL_TICK(pll_tick), .ENb_CP(enb_cp), .ENb_VCO(enb_vco),
    .B(b), .LOCK(lock), .FAULT(fault), .FREQ_CNT(freq_cnt), .CNT_VALID(cnt_valid),
    .STATE(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int st;
    int lk;
    int ft;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   m_state, m_hits, m_miss, m_tmo, m_b, m_win, m_tol;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while ((int'(state) != s) && (n < budget)) begin
      tick();
      n++;
    end
    chk(name, int'(state), s);
  endtask

  task automatic model_restart(input int bv, input int wv);
    m_state = 3;
    m_hits  = 0;
    m_miss  = 0;
    m_tmo   = 0;
    m_b     = bv;
    m_win   = wv;
  endtask

  // Reference judgement of one completed window, straight from the lock rules.
  task automatic model_push(input int n);
    int   d;
    bit   pass;
    exp_t e;
    d = n - m_win * m_b;
    pass = (d <= m_tol) && (d >= -m_tol);
    if (m_state == 3) begin
      if (pass) begin
        m_hits++;
        if (m_hits == HITS) begin
          m_state = 4;
          m_hits  = 0;
          m_miss  = 0;
        end
      end else begin
        m_hits = 0;
        m_tmo++;
        if (m_tmo == TMO) m_state = 5;
      end
    end else if (m_state == 4) begin
      if (pass) begin
        m_miss = 0;
      end else begin
        m_miss++;
        if (m_miss == MISSES) begin
          m_state = 3;
          m_miss  = 0;
          m_hits  = 0;
          m_tmo   = 0;
        end
      end
    end
    e.cnt = n;
    e.st  = m_state;
    e.lk  = (m_state == 4) ? 1 : 0;
    e.ft  = (m_state == 5) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic open_window();
    ref_tick = 1'b1;
    pll_tick = 1'b1;
    tick();
    ref_tick = 1'b0;
    pll_tick = 1'b0;
  endtask

  // Scatters exactly n PLL ticks at random over the window's cycles, REF cycles included.
  task automatic drive_window(input int n);
    int slots;
    int left;
    left  = n;
    slots = m_win * (GAP + 1);
    for (int k = 0; k < m_win; k++) begin
      for (int j = 0; j <= GAP; j++) begin
        pll_tick = (int'($urandom_range(slots - 1)) < left) ? 1'b1 : 1'b0;
        if (pll_tick) left--;
        slots--;
        ref_tick = (j == GAP) ? 1'b1 : 1'b0;
        if ((j == GAP) && (k == m_win - 1)) model_push(n);
        tick();
      end
    end
    ref_tick = 1'b0;
    pll_tick = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rstb && cnt_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_freq_cnt", int'(freq_cnt), mon_e.cnt);
        chk("sb_state", int'(state), mon_e.st);
        chk("sb_lock", int'(lock), mon_e.lk);
        chk("sb_fault", int'(fault), mon_e.ft);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lock_seq[8]   = '{32, 32, 34, 35, 32, 33, 30, 34};
    int unlock_seq[5] = '{32, 20, 32, 20, 20};
    int div_seq[4]    = '{40, 41, 39, 40};
    int one_seq[6]    = '{1, 4, 1, 0, 2, 1};

    rstb = 1'b0; en = 1'b1; div = 4'd8; win = 8'd4; tol = 8'd2;
    m_tol = 2;
    tick();
    tick();
    chk("rst_enb_cp", int'(enb_cp), 1);
    chk("rst_enb_vco", int'(enb_vco), 1);
    chk("rst_b", int'(b), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_freq_cnt", int'(freq_cnt), 0);
    chk("rst_cnt_valid", int'(cnt_valid), 0);

    rstb = 1'b1;
    tick();
    chk("pwr_b", int'(b), 8);
    chk("pwr_state_cp", int'(state), 1);
    chk("pwr_enb_cp", int'(enb_cp), 0);
    chk("pwr_enb_vco", int'(enb_vco), 1);
    n = 0;
    while (enb_vco && (n < 200)) begin tick(); n++; end
    chk("cp_settle_cycles", n, CP_S);
    n = 0;
    while ((state != 3'd3) && (n < 200)) begin tick(); n++; end
    chk("vco_settle_cycles", n, VCO_S);
    chk("acq_enb_cp", int'(enb_cp), 0);

    model_restart(8, 4);
    open_window();
    foreach (lock_seq[i]) drive_window(lock_seq[i]);
    tick();
    chk("locked_lock", int'(lock), 1);

    foreach (unlock_seq[i]) drive_window(unlock_seq[i]);
    tick();
    chk("unlock_state", int'(state), 3);
    chk("unlock_lock", int'(lock), 0);

    for (int i = 0; i < 4; i++) drive_window(32);
    for (int i = 0; i < 24; i++) begin
      drive_window(m_win * m_b + int'($urandom_range(6)) - 3);
      if (m_state == 5) break;
    end

    en = 1'b0;
    tick();
    chk("off_state", int'(state), 0);
    chk("off_enb_cp", int'(enb_cp), 1);
    chk("off_enb_vco", int'(enb_vco), 1);
    chk("off_lock", int'(lock), 0);
    chk("off_b_hold", int'(b), 8);

    en = 1'b1;
    wait_state(3, 200, "restart_acq");
    model_restart(8, 4);
    open_window();
    for (int i = 0; i < TMO; i++) drive_window(0);
    tick();
    chk("fault_flag", int'(fault), 1);
    chk("fault_enb_cp", int'(enb_cp), 1);
    chk("fault_enb_vco", int'(enb_vco), 1);
    for (int i = 0; i < 6; i++) begin ref_tick = 1'b1; tick(); ref_tick = 1'b0; tick(); end
    chk("fault_held", int'(state), 5);
    en = 1'b0;
    tick();
    chk("fault_clear_state", int'(state), 0);
    chk("fault_clear_flag", int'(fault), 0);

    en = 1'b1;
    wait_state(3, 200, "restart2_acq");
    model_restart(8, 4);
    open_window();
    for (int i = 0; i < 4; i++) drive_window(32);
    tick();
    chk("relock_lock", int'(lock), 1);

    div = 4'd10;
    tick();
    chk("divchg_b", int'(b), 10);
    chk("divchg_lock", int'(lock), 0);
    chk("divchg_state", int'(state), 3);
    model_restart(10, 4);
    open_window();
    foreach (div_seq[i]) drive_window(div_seq[i]);
    tick();
    chk("div10_lock", int'(lock), 1);

    en = 1'b0; div = 4'd0; win = 8'd0;
    tick();
    chk("off2_b_hold", int'(b), 10);
    en = 1'b1;
    tick();
    chk("div0_b", int'(b), 1);
    wait_state(3, 200, "restart3_acq");
    model_restart(1, 1);
    open_window();
    foreach (one_seq[i]) drive_window(one_seq[i]);
    tick();
    chk("win1_state", int'(state), 4);

    rstb = 1'b0;
    tick();
    chk("midrst_state", int'(state), 0);
    chk("midrst_lock", int'(lock), 0);
    chk("midrst_b", int'(b), 0);
    chk("midrst_freq_cnt", int'(freq_cnt), 0);
    rstb = 1'b1;
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
